// File: rtl/eth_filter_pkg.sv
// Shared types and constants for the RX destination-address filter.
// Holds the FIFO entry layout, output FSM states and header constants.
package eth_filter_pkg;

  localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;
  localparam int          HDR_BYTES  = 6;
  localparam int          DEC_DEPTH  = 2;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_PASS,
    ST_DISCARD
  } out_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/eth_sync_fifo.sv
// Single-clock show-ahead FIFO with registered full/empty flags.
// Ports: push/din write, pop/dout read (dout valid when !empty), full, empty.
module eth_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign count_nxt = count + {{AW{1'b0}}, do_push}
                           - {{AW{1'b0}}, do_pop};
  assign dout      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/eth_rx_addr_filter.sv
// Destination-MAC filter: buffers bytes, decides on byte 5, forwards or drops.
// Ports: s_axis in, m_axis out (registered), cfg_* modes, stat_* counters.
module eth_rx_addr_filter
  import eth_filter_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic [47:0]          cfg_mac_addr,
  input  logic                 cfg_promisc,
  input  logic                 cfg_allow_bcast,
  input  logic                 cfg_allow_mcast,
  output logic [CNT_WIDTH-1:0] stat_accept_cnt,
  output logic [CNT_WIDTH-1:0] stat_drop_cnt,
  output logic [CNT_WIDTH-1:0] stat_runt_cnt
);

  localparam logic [2:0] IDX_SAT  = 3'(HDR_BYTES);
  localparam logic [2:0] LAST_HDR = 3'(HDR_BYTES - 1);

  logic [2:0]  idx;
  logic [47:0] mac_q;
  logic        promisc_q, bcast_q, mcast_q;
  logic        uc_q, bc_q, mc_q;
  logic        first;
  logic [47:0] mac_cur, mac_sh;
  logic        promisc_cur, bcast_cur, mcast_cur;
  logic        uc_n, bc_n, mc_n;
  logic        accept, decide, runt;

  // Byte 0 compares against live cfg, which is latched on that same edge.
  assign first       = (idx == 3'd0);
  assign mac_cur     = first ? cfg_mac_addr    : mac_q;
  assign promisc_cur = first ? cfg_promisc     : promisc_q;
  assign bcast_cur   = first ? cfg_allow_bcast : bcast_q;
  assign mcast_cur   = first ? cfg_allow_mcast : mcast_q;
  assign mac_sh      = mac_cur << {idx, 3'b000};

  assign uc_n = (s_axis_tdata == mac_sh[47:40]) & (first | uc_q);
  assign bc_n = (s_axis_tdata == BCAST_ADDR[7:0]) & (first | bc_q);
  assign mc_n = first ? s_axis_tdata[0] : mc_q;

  assign accept = promisc_cur | uc_n | (bc_n & bcast_cur)
                | (mc_n & ~bc_n & mcast_cur);
  assign decide = s_axis_tvalid & (idx == LAST_HDR);
  assign runt   = s_axis_tvalid & s_axis_tlast & (idx < LAST_HDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      mac_q     <= '0;
      promisc_q <= 1'b0;
      bcast_q   <= 1'b0;
      mcast_q   <= 1'b0;
      uc_q      <= 1'b0;
      bc_q      <= 1'b0;
      mc_q      <= 1'b0;
    end else if (s_axis_tvalid) begin
      if (first) begin
        mac_q     <= cfg_mac_addr;
        promisc_q <= cfg_promisc;
        bcast_q   <= cfg_allow_bcast;
        mcast_q   <= cfg_allow_mcast;
      end
      if (idx < IDX_SAT) begin
        uc_q <= uc_n;
        bc_q <= bc_n;
        mc_q <= mc_n;
      end
      if (s_axis_tlast)         idx <= '0;
      else if (idx != IDX_SAT)  idx <= idx + 3'd1;
    end
  end

  logic                   data_push, data_pop, data_full, data_empty;
  fifo_entry_t            din_e, dout_e;
  logic [ENTRY_W-1:0]     dout_raw;

  assign din_e     = '{data: s_axis_tdata,
                       last: s_axis_tlast,
                       user: s_axis_tuser};
  assign data_push = s_axis_tvalid & ~data_full;
  assign dout_e    = fifo_entry_t'(dout_raw);

  eth_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (data_push),
    .din   (din_e),
    .pop   (data_pop),
    .dout  (dout_raw),
    .full  (data_full),
    .empty (data_empty)
  );

  logic       dec_push, dec_pop, dec_full, dec_empty;
  logic [0:0] dec_din, dec_dout;
  logic       last_dec_q;

  assign dec_push = decide | runt;
  assign dec_din  = decide & accept;

  eth_sync_fifo #(.WIDTH(1), .DEPTH(DEC_DEPTH)) u_dec_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (dec_push),
    .din   (dec_din),
    .pop   (dec_pop),
    .dout  (dec_dout),
    .full  (dec_full),
    .empty (dec_empty)
  );

  out_state_e state;

  assign data_pop = (state != ST_WAIT) & ~data_empty;
  assign dec_pop  = data_pop & dout_e.last;

  // With two decisions queued, the one behind the head is the latest push,
  // so the next frame can start without a WAIT bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dec_q <= 1'b0;
    end else if (dec_push & ~dec_full) begin
      last_dec_q <= dec_din[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_WAIT;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      unique case (state)
        ST_WAIT: begin
          if (!dec_empty)
            state <= dec_dout[0] ? ST_PASS : ST_DISCARD;
        end
        ST_PASS, ST_DISCARD: begin
          if (data_pop) begin
            if (state == ST_PASS) begin
              m_axis_tdata  <= dout_e.data;
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= dout_e.last;
              m_axis_tuser  <= dout_e.user;
            end
            if (dout_e.last) begin
              if (dec_full)
                state <= last_dec_q ? ST_PASS : ST_DISCARD;
              else
                state <= ST_WAIT;
            end
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_accept_cnt <= '0;
      stat_drop_cnt   <= '0;
      stat_runt_cnt   <= '0;
    end else begin
      if (decide & accept & ~&stat_accept_cnt)
        stat_accept_cnt <= stat_accept_cnt + CNT_WIDTH'(1);
      if (decide & ~accept & ~&stat_drop_cnt)
        stat_drop_cnt <= stat_drop_cnt + CNT_WIDTH'(1);
      if (runt & ~&stat_runt_cnt)
        stat_runt_cnt <= stat_runt_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// Directed testbench for eth_rx_addr_filter.
// Drives frames on s_axis, records m_axis, compares against expectations.
module tb_eth_rx_addr_filter;

  localparam logic [47:0] MAC   = 48'h0200_0000_0001;
  localparam logic [47:0] OTHER = 48'h0200_0000_0002;
  localparam logic [47:0] DROPD = 48'h0200_0000_0003;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MCAST = 48'h0100_5E00_0001;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [47:0] cfg_mac_addr;
  logic        cfg_promisc;
  logic        cfg_allow_bcast;
  logic        cfg_allow_mcast;
  logic [15:0] stat_accept_cnt;
  logic [15:0] stat_drop_cnt;
  logic [15:0] stat_runt_cnt;

  eth_rx_addr_filter #(.CNT_WIDTH(16), .FIFO_DEPTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tuser    (s_axis_tuser),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser    (m_axis_tuser),
    .cfg_mac_addr    (cfg_mac_addr),
    .cfg_promisc     (cfg_promisc),
    .cfg_allow_bcast (cfg_allow_bcast),
    .cfg_allow_mcast (cfg_allow_mcast),
    .stat_accept_cnt (stat_accept_cnt),
    .stat_drop_cnt   (stat_drop_cnt),
    .stat_runt_cnt   (stat_runt_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_dec = 0;
  int ovf = 0;
  int exp_acc = 0;
  int exp_drop = 0;
  int exp_runt = 0;
  logic [9:0] out_q [$];
  logic [9:0] exp_q [$];
  int         out_cyc [$];

  initial clk = 1'b0;
  always #4 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk)
    if (rst_n && s_axis_tvalid && dut.data_full) ovf++;

  always @(negedge clk)
    if (m_axis_tvalid) begin
      out_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
      out_cyc.push_back(cyc);
    end

  function automatic int count_mismatch();
    int m;
    m = (out_q.size() > exp_q.size()) ? out_q.size() - exp_q.size()
                                      : exp_q.size() - out_q.size();
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      if (out_q[i] !== exp_q[i]) m++;
    return m;
  endfunction

  task automatic clear_q();
    out_q.delete();
    out_cyc.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tdata  = 8'h00;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [47:0] dst, input int len,
                            input logic user_last, input logic pass);
    logic [7:0] b;
    logic       lst, usr;
    for (int i = 0; i < len; i++) begin
      if (i < 6) b = dst[8*(5-i) +: 8];
      else       b = 8'(i * 13 + len);
      lst = (i == len - 1);
      usr = lst ? user_last : 1'b0;
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b;
      s_axis_tlast  = lst;
      s_axis_tuser  = usr;
      if (i == 5) n_dec = cyc + 1;
      if (pass) exp_q.push_back({b, lst, usr});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 11'd0) begin
      errors++;
      $display("FAIL rst_out got v=%b l=%b u=%b d=%h want all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata);
    end
    checks++;
    if ({stat_accept_cnt, stat_drop_cnt, stat_runt_cnt} !== 48'd0) begin
      errors++;
      $display("FAIL rst_cnt got %0d/%0d/%0d want 0/0/0",
               stat_accept_cnt, stat_drop_cnt, stat_runt_cnt);
    end
    rst_n = 1'b1;
    idle(3);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got tvalid=%b want 0", m_axis_tvalid);
    end
  endtask

  task automatic test_unicast();
    int first;
    clear_q();
    send_frame(MAC, 64, 1'b0, 1'b1);
    exp_acc++;
    idle(20);
    checks++;
    if (out_q.size() !== 64) begin
      errors++;
      $display("FAIL uc_len got %0d want 64", out_q.size());
    end
    checks++;
    if (count_mismatch() !== 0) begin
      errors++;
      $display("FAIL uc_data got %0d bad bytes want 0", count_mismatch());
    end
    first = (out_cyc.size() > 0) ? out_cyc[0] : -1;
    checks++;
    if (first !== n_dec + 2) begin
      errors++;
      $display("FAIL uc_latency got edge %0d want %0d", first, n_dec + 2);
    end
    checks++;
    if ({stat_accept_cnt, stat_drop_cnt, stat_runt_cnt} !==
        {16'(exp_acc), 16'(exp_drop), 16'(exp_runt)}) begin
      errors++;
      $display("FAIL uc_cnt got %0d/%0d/%0d want %0d/%0d/%0d",
               stat_accept_cnt, stat_drop_cnt, stat_runt_cnt,
               exp_acc, exp_drop, exp_runt);
    end
  endtask

  task automatic test_mismatch();
    clear_q();
    send_frame(OTHER, 64, 1'b0, 1'b0);
    exp_drop++;
    idle(20);
    checks++;
    if (out_q.size() !== 0) begin
      errors++;
      $display("FAIL mm_len got %0d want 0", out_q.size());
    end
    checks++;
    if ({stat_accept_cnt, stat_drop_cnt, stat_runt_cnt} !==
        {16'(exp_acc), 16'(exp_drop), 16'(exp_runt)}) begin
      errors++;
      $display("FAIL mm_cnt got %0d/%0d/%0d want %0d/%0d/%0d",
               stat_accept_cnt, stat_drop_cnt, stat_runt_cnt,
               exp_acc, exp_drop, exp_runt);
    end
  endtask

  task automatic test_bcast_mcast();
    cfg_allow_bcast = 1'b0;
    cfg_allow_mcast = 1'b0;
    clear_q();
    send_frame(BCAST, 20, 1'b0, 1'b0);
    exp_drop++;
    idle(20);
    checks++;
    if (out_q.size() !== 0) begin
      errors++;
      $display("FAIL bc_off_len got %0d want 0", out_q.size());
    end
    cfg_allow_bcast = 1'b1;
    clear_q();
    send_frame(BCAST, 20, 1'b0, 1'b1);
    exp_acc++;
    idle(20);
    checks++;
    if (count_mismatch() !== 0 || out_q.size() !== 20) begin
      errors++;
      $display("FAIL bc_on got %0d bytes (%0d bad) want 20",
               out_q.size(), count_mismatch());
    end
    cfg_allow_bcast = 1'b0;
    cfg_allow_mcast = 1'b1;
    clear_q();
    send_frame(MCAST, 24, 1'b0, 1'b1);
    exp_acc++;
    idle(20);
    checks++;
    if (count_mismatch() !== 0 || out_q.size() !== 24) begin
      errors++;
      $display("FAIL mc_on got %0d bytes (%0d bad) want 24",
               out_q.size(), count_mismatch());
    end
    cfg_allow_mcast = 1'b0;
    checks++;
    if ({stat_accept_cnt, stat_drop_cnt, stat_runt_cnt} !==
        {16'(exp_acc), 16'(exp_drop), 16'(exp_runt)}) begin
      errors++;
      $display("FAIL bcmc_cnt got %0d/%0d/%0d want %0d/%0d/%0d",
               stat_accept_cnt, stat_drop_cnt, stat_runt_cnt,
               exp_acc, exp_drop, exp_runt);
    end
  endtask

  task automatic test_runt();
    clear_q();
    send_frame(MAC, 4, 1'b0, 1'b0);
    exp_runt++;
    send_frame(MAC, 20, 1'b0, 1'b1);
    exp_acc++;
    idle(20);
    checks++;
    if (count_mismatch() !== 0 || out_q.size() !== 20) begin
      errors++;
      $display("FAIL runt_out got %0d bytes (%0d bad) want 20",
               out_q.size(), count_mismatch());
    end
    checks++;
    if ({stat_accept_cnt, stat_drop_cnt, stat_runt_cnt} !==
        {16'(exp_acc), 16'(exp_drop), 16'(exp_runt)}) begin
      errors++;
      $display("FAIL runt_cnt got %0d/%0d/%0d want %0d/%0d/%0d",
               stat_accept_cnt, stat_drop_cnt, stat_runt_cnt,
               exp_acc, exp_drop, exp_runt);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] tail;
    clear_q();
    ovf = 0;
    send_frame(MAC, 60, 1'b0, 1'b1);
    send_frame(DROPD, 60, 1'b0, 1'b0);
    send_frame(MAC, 60, 1'b1, 1'b1);
    exp_acc += 2;
    exp_drop++;
    idle(30);
    checks++;
    if (out_q.size() !== 120) begin
      errors++;
      $display("FAIL b2b_len got %0d want 120", out_q.size());
    end
    checks++;
    if (count_mismatch() !== 0) begin
      errors++;
      $display("FAIL b2b_data got %0d bad bytes want 0", count_mismatch());
    end
    tail = (out_q.size() > 0) ? out_q[out_q.size() - 1] : 10'd0;
    checks++;
    if (tail[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL b2b_tuser got last=%b user=%b want 1/1", tail[1], tail[0]);
    end
    checks++;
    if (ovf !== 0) begin
      errors++;
      $display("FAIL b2b_full_push got %0d want 0", ovf);
    end
    checks++;
    if ({stat_accept_cnt, stat_drop_cnt, stat_runt_cnt} !==
        {16'(exp_acc), 16'(exp_drop), 16'(exp_runt)}) begin
      errors++;
      $display("FAIL b2b_cnt got %0d/%0d/%0d want %0d/%0d/%0d",
               stat_accept_cnt, stat_drop_cnt, stat_runt_cnt,
               exp_acc, exp_drop, exp_runt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    clear_q();
    for (int i = 0; i < 20; i++) begin
      b = (i < 6) ? MAC[8*(5-i) +: 8] : 8'(i * 5);
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (out_q.size() == 0) begin
      errors++;
      $display("FAIL mid_active got %0d bytes want >0", out_q.size());
    end
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 11'd0) begin
      errors++;
      $display("FAIL mid_out got v=%b d=%h want 0", m_axis_tvalid, m_axis_tdata);
    end
    checks++;
    if ({stat_accept_cnt, stat_drop_cnt, stat_runt_cnt} !== 48'd0) begin
      errors++;
      $display("FAIL mid_cnt got %0d/%0d/%0d want 0/0/0",
               stat_accept_cnt, stat_drop_cnt, stat_runt_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_acc  = 0;
    exp_drop = 0;
    exp_runt = 0;
    idle(2);
    clear_q();
    send_frame(MAC, 30, 1'b0, 1'b1);
    send_frame(OTHER, 30, 1'b0, 1'b0);
    exp_acc++;
    exp_drop++;
    idle(20);
    checks++;
    if (count_mismatch() !== 0 || out_q.size() !== 30) begin
      errors++;
      $display("FAIL mid_after got %0d bytes (%0d bad) want 30",
               out_q.size(), count_mismatch());
    end
    checks++;
    if ({stat_accept_cnt, stat_drop_cnt, stat_runt_cnt} !==
        {16'(exp_acc), 16'(exp_drop), 16'(exp_runt)}) begin
      errors++;
      $display("FAIL mid_after_cnt got %0d/%0d/%0d want %0d/%0d/%0d",
               stat_accept_cnt, stat_drop_cnt, stat_runt_cnt,
               exp_acc, exp_drop, exp_runt);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    s_axis_tdata    = 8'h00;
    s_axis_tvalid   = 1'b0;
    s_axis_tlast    = 1'b0;
    s_axis_tuser    = 1'b0;
    cfg_mac_addr    = MAC;
    cfg_promisc     = 1'b0;
    cfg_allow_bcast = 1'b0;
    cfg_allow_mcast = 1'b0;
    test_reset();
    test_unicast();
    test_mismatch();
    test_bcast_mcast();
    test_runt();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
